// File: rtl/ftc_seq_pkg.sv
// Shared types for the FTC vector sequencer: FSM state encoding and vector-word layout.
package ftc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Bit positions inside one 8-bit vector word
    localparam int CIN_B  = 7;
    localparam int I_HI   = 6;
    localparam int I_LO   = 3;
    localparam int C_B    = 2;
    localparam int COUT_B = 1;
    localparam int S_B    = 0;

    typedef struct packed {
        logic       cin;
        logic [3:0] i;
        logic       c;
        logic       cout;
        logic       s;
    } vec_t;

endpackage

// File: rtl/ftc_vec_ram.sv
// NUM_VEC x 8 vector store: synchronous write, asynchronous read, write-first bypass.
module ftc_vec_ram
    import ftc_seq_pkg::*;
#(
    parameter int NUM_VEC = 16,
    parameter int AW      = $clog2(NUM_VEC)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  vec_t          wdata,
    input  logic [AW-1:0] raddr,
    output vec_t          rdata
);

    vec_t mem [NUM_VEC];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write to the read address is forwarded so the reader sees the new word
    assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/ftc_vec_sequencer.sv
// Self-checking stimulus/compare controller for an external four-to-two compressor cell.
// Optional build macro FTC_SEQ_STOP_ON_ERR_EN ends the run at the first mismatching vector.
module ftc_vec_sequencer
    import ftc_seq_pkg::*;
#(
    parameter int NUM_VEC = 16,
    parameter int AW      = $clog2(NUM_VEC),
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [AW:0]      num_vec,
    input  logic             start,
    output logic             dut_cin,
    output logic [3:0]       dut_i,
    input  logic             dut_c,
    input  logic             dut_cout,
    input  logic             dut_s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [AW-1:0]    first_err_idx
);

    // Settle counter runs 0..DUT_LAT-1
    localparam int SW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     idx;
    logic [AW:0]       nv_q;
    logic [AW:0]       nv_clamp;
    logic [SW-1:0]     settle_cnt;
    logic [2:0]        exp_q;
    vec_t              rd_word;
    logic [ERR_W-1:0]  err_nxt;
    logic              running;
    logic              ram_we;
    logic              last_vec;
    logic              mismatch;
    logic              settle_end;
    logic              accept;
    logic              load_stim;
    logic              do_check;
    logic              enter_done;

    assign running    = (state == APPLY) || (state == SETTLE) || (state == CHECK);
    assign ram_we     = wr_en && !running;
    assign nv_clamp   = (num_vec > (AW+1)'(NUM_VEC)) ? (AW+1)'(NUM_VEC) : num_vec;
    assign last_vec   = ({1'b0, idx} == (nv_q - (AW+1)'(1)));
    assign mismatch   = ({dut_c, dut_cout, dut_s} != exp_q);
    assign settle_end = (settle_cnt == SW'(DUT_LAT - 1));

    ftc_vec_ram #(
        .NUM_VEC (NUM_VEC),
        .AW      (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (nv_clamp == '0) ? DONE : APPLY;
                end
            end
            APPLY: begin
                state_nxt = (DUT_LAT > 0) ? SETTLE : CHECK;
            end
            SETTLE: begin
                if (settle_end) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = last_vec ? DONE : APPLY;
`ifdef FTC_SEQ_STOP_ON_ERR_EN
                if (mismatch) begin
                    state_nxt = DONE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept     = ((state == IDLE) || (state == DONE)) && start;
        load_stim  = (state == APPLY);
        do_check   = (state == CHECK);
        enter_done = accept ? (nv_clamp == '0) : (do_check && (state_nxt == DONE));
        err_nxt    = err_cnt;
        if (accept) begin
            err_nxt = '0;
        end else if (do_check && mismatch && (err_cnt != '1)) begin
            err_nxt = err_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            nv_q          <= '0;
            settle_cnt    <= '0;
            exp_q         <= '0;
            dut_cin       <= 1'b0;
            dut_i         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b1;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else begin
            done    <= enter_done;
            busy    <= (state_nxt == APPLY) || (state_nxt == SETTLE) || (state_nxt == CHECK);
            err_cnt <= err_nxt;
            if (enter_done) begin
                pass <= (err_nxt == '0);
            end
            if (accept) begin
                first_err_vld <= 1'b0;
                first_err_idx <= '0;
                nv_q          <= nv_clamp;
                idx           <= '0;
            end
            if (load_stim) begin
                dut_cin    <= rd_word[CIN_B];
                dut_i      <= rd_word[I_HI:I_LO];
                exp_q      <= {rd_word[C_B], rd_word[COUT_B], rd_word[S_B]};
                settle_cnt <= '0;
            end
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SW'(1);
            end
            if (do_check) begin
                if (mismatch && !first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_idx <= idx;
                end
                if (!last_vec) begin
                    idx <= idx + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ftc_vec_sequencer.sv
// Directed bench: two sequencers (combinational and 2-cycle-latency FTC) around a behavioural FTC.
module tb_ftc_vec_sequencer;

    localparam int NUM_VEC = 16;
    localparam int AW      = 4;
`ifdef FTC_SEQ_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [AW:0]   num_vec = '0;
    logic          start0 = 1'b0;
    logic          start1 = 1'b0;
    logic          stuck_s = 1'b0;

    logic          cin0, c0, cout0, s0, busy0, done0, pass0, fvld0;
    logic [3:0]    i0;
    logic [6:0]    err0;
    logic [AW-1:0] fidx0;
    logic [2:0]    ftc0;
    logic          cin1, c1, cout1, s1, busy1, done1, pass1, fvld1;
    logic [3:0]    i1;
    logic [2:0]    err1;
    logic [AW-1:0] fidx1;
    logic [2:0]    ftc1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Reference FTC: full adder on I1..I3, then full adder on (sum, I4, Cin); returns {C, Cout, S}
    function automatic logic [2:0] ftc(input logic cin, input logic [3:0] i);
        logic sa, co, s, c;
        sa = i[0] ^ i[1] ^ i[2];
        co = (i[0] & i[1]) | (i[0] & i[2]) | (i[1] & i[2]);
        s  = sa ^ i[3] ^ cin;
        c  = (sa & i[3]) | (sa & cin) | (i[3] & cin);
        return {c, co, s};
    endfunction

    assign ftc0  = ftc(cin0, i0);
    assign c0    = ftc0[2];
    assign cout0 = ftc0[1];
    assign s0    = ftc0[0] & ~stuck_s;
    assign ftc1  = ftc(cin1, i1);
    assign c1    = ftc1[2];
    assign cout1 = ftc1[1];
    assign s1    = ftc1[0] & ~stuck_s;

    ftc_vec_sequencer #(.NUM_VEC(NUM_VEC), .DUT_LAT(0), .ERR_W(7)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vec(num_vec), .start(start0), .dut_cin(cin0), .dut_i(i0), .dut_c(c0),
        .dut_cout(cout0), .dut_s(s0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_err_vld(fvld0), .first_err_idx(fidx0)
    );

    ftc_vec_sequencer #(.NUM_VEC(NUM_VEC), .DUT_LAT(2), .ERR_W(3)) u_dut_lat (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vec(num_vec), .start(start1), .dut_cin(cin1), .dut_i(i1), .dut_c(c1),
        .dut_cout(cout1), .dut_s(s1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_err_vld(fvld1), .first_err_idx(fidx1)
    );

    // Hand-computed correct FTC words {Cin, I4..I1, C, Cout, S}
    logic [7:0] vec_tab [9] = '{8'h00, 8'h09, 8'h81, 8'h1A, 8'h3B, 8'hC4, 8'hFF, 8'h4C, 8'hB3};

    typedef struct {
        string name;
        int    nv;
        int    flip;
        bit    stuck;
        int    cyc;
        int    pass;
        int    err;
        int    fvld;
        int    fidx;
    } scen_t;

    scen_t sc [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic load_all(input int flip);
        logic [7:0] w;
        for (int a = 0; a < NUM_VEC; a++) begin
            w = vec_tab[a % 9];
            if (a == flip) w[0] = ~w[0];
            wr(4'(a), w);
        end
    endtask

    task automatic kick(input bit sel, input int nv);
        @(negedge clk);
        num_vec = 5'(nv);
        if (sel) start1 = 1'b1;
        else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, inout int cycles);
        while (((sel ? done1 : done0) == 1'b0) && (cycles < 300)) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_pass"}, pass0, 1);
        check({tag, "_err"}, err0, 0);
        check({tag, "_fvld"}, fvld0, 0);
        check({tag, "_fidx"}, fidx0, 0);
        check({tag, "_stim"}, {cin0, i0}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [7:0] w;

        sc[0] = '{"clean9",   9, -1, 1'b0, 18,               1, 0,               0, 0};
        sc[1] = '{"flip4",    9,  4, 1'b0, STOP ? 10 : 18,   0, 1,               1, 4};
        sc[2] = '{"stuck9",   9, -1, 1'b1, STOP ? 4 : 18,    0, STOP ? 1 : 5,    1, 1};
        sc[3] = '{"empty",    0, -1, 1'b0, 0,                1, 0,               0, 0};
        sc[4] = '{"clamp31", 31, -1, 1'b0, 32,               1, 0,               0, 0};
        sc[5] = '{"part3",    3, -1, 1'b0, 6,                1, 0,               0, 0};
        sc[6] = '{"stuck1",   1, -1, 1'b1, 2,                1, 0,               0, 0};
        sc[7] = '{"stuck16", 16, -1, 1'b1, STOP ? 4 : 32,    0, STOP ? 1 : 9,    1, 1};

        repeat (3) @(posedge clk);
        #1;
        check_reset0("reset");
        check("reset_lat_pass", pass1, 1);
        check("reset_lat_busy", busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            load_all(sc[k].flip);
            stuck_s = sc[k].stuck;
            kick(1'b0, sc[k].nv);
            cyc = 0;
            wait_done(1'b0, cyc);
            check({sc[k].name, "_cycles"}, cyc, sc[k].cyc);
            check({sc[k].name, "_done"}, done0, 1);
            check({sc[k].name, "_busy"}, busy0, 0);
            check({sc[k].name, "_pass"}, pass0, sc[k].pass);
            check({sc[k].name, "_err"}, err0, sc[k].err);
            check({sc[k].name, "_fvld"}, fvld0, sc[k].fvld);
            check({sc[k].name, "_fidx"}, fidx0, sc[k].fidx);
            @(posedge clk);
            #1;
            check({sc[k].name, "_done_pulse"}, done0, 0);
            check({sc[k].name, "_pass_hold"}, pass0, sc[k].pass);
        end
        stuck_s = 1'b0;
        load_all(-1);

        // DUT_LAT=2: 4 cycles per vector, stimulus held through SETTLE
        kick(1'b1, 3);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            w = vec_tab[(k - 1) / 4];
            check($sformatf("lat_stim_%0d", k), {cin1, i1}, w[7:3]);
            check($sformatf("lat_done_%0d", k), done1, (k == 12) ? 1 : 0);
        end
        check("lat_pass", pass1, 1);
        @(posedge clk);
        #1;
        w = vec_tab[2];
        check("lat_stim_hold", {cin1, i1}, w[7:3]);

        // Error counter saturates at 7 with ERR_W=3
        stuck_s = 1'b1;
        kick(1'b1, 16);
        cyc = 0;
        wait_done(1'b1, cyc);
        check("sat_cycles", cyc, STOP ? 8 : 64);
        check("sat_err", err1, STOP ? 1 : 7);
        check("sat_fidx", fidx1, 1);
        check("sat_pass", pass1, 0);
        stuck_s = 1'b0;

        // Start and write in the same idle cycle: vector 0 sees the new word
        @(negedge clk);
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'h01; num_vec = 5'd1; start0 = 1'b1;
        @(posedge clk);
        #1 wr_en = 1'b0; start0 = 1'b0;
        cyc = 0;
        wait_done(1'b0, cyc);
        check("wrstart_cycles", cyc, 2);
        check("wrstart_err", err0, 1);
        check("wrstart_fvld", fvld0, 1);
        check("wrstart_fidx", fidx0, 0);
        check("wrstart_pass", pass0, 0);
        wr('0, vec_tab[0]);

        // Mid-run start and write are both ignored
        kick(1'b0, 9);
        cyc = 0;
        repeat (5) begin
            @(posedge clk);
            #1 cyc++;
        end
        @(negedge clk);
        start0 = 1'b1; num_vec = 5'd1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h87;
        @(posedge clk);
        #1 start0 = 1'b0; wr_en = 1'b0;
        cyc++;
        check("midrun_busy", busy0, 1);
        wait_done(1'b0, cyc);
        check("midrun_cycles", cyc, 18);
        check("midrun_pass", pass0, 1);
        kick(1'b0, 9);
        cyc = 0;
        wait_done(1'b0, cyc);
        check("readback_pass", pass0, 1);
        check("readback_err", err0, 0);
        wr(4'd2, vec_tab[2]);

        // Reset during vector 5
        stuck_s = 1'b1;
        kick(1'b0, 9);
        repeat (11) @(posedge clk);
        #1;
        check("prereset_err", err0, STOP ? 1 : 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset0("midreset");
        stuck_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        kick(1'b0, 9);
        cyc = 0;
        wait_done(1'b0, cyc);
        check("rerun_cycles", cyc, 18);
        check("rerun_pass", pass0, 1);
        check("rerun_err", err0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ftc_vec_sequencer.md
Name: ftc_vec_sequencer

Overview:
- Self-checking vector sequencer for the four-to-two compressor (FTC) adder cell.
- Holds a small vector RAM. On start, drives each stored stimulus onto the external FTC, waits a configurable settle time, then compares C/Cout/S against the stored expected bits.
- Counts mismatches and captures the index of the first failing vector.
- Sits beside the FTC datapath as its controller and replaces file-driven checking for on-chip/regression use.

Parameters:
- NUM_VEC, 16: vector RAM depth; must be ≥ 2.
- AW, $clog2(NUM_VEC): address/index width.
- DUT_LAT, 0: extra settle cycles between stimulus and output sampling; 0 means a combinational FTC.
- ERR_W, 7: error counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  vector RAM write strobe; ignored while busy=1
- wr_addr  in  AW  vector RAM write address
- wr_data  in  8  vector word: [7]=Cin, [6:3]=I4..I1, [2]=C exp, [1]=Cout exp, [0]=S exp
- num_vec  in  AW+1  number of vectors to run, 0..NUM_VEC; sampled on start
- start  in  1  one-cycle run request; accepted only in IDLE or DONE
- dut_cin  out  1  FTC Cin stimulus
- dut_i  out  4  FTC I4..I1 stimulus, dut_i[0]=I1
- dut_c  in  1  FTC C output
- dut_cout  in  1  FTC Cout output
- dut_s  in  1  FTC S output
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  err_cnt==0 after the last completed run
- err_cnt  out  ERR_W  mismatch count, saturating
- first_err_vld  out  1  at least one mismatch this run
- first_err_idx  out  AW  index of the first mismatching vector

Behaviour:
- Reset values: all outputs 0 except pass=1. Vector RAM contents are not reset.
- Output timing: stimulus outputs are registered; status outputs are registered.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE + start:
  - clears err_cnt, first_err_vld and first_err_idx;
  - latches num_vec and sets idx=0.
  - If num_vec==0: go to DONE with done=1 and pass=1 on the next cycle.
  - Otherwise: go to APPLY with busy=1.
- APPLY (1 cycle): load dut_cin/dut_i from RAM[idx]; latch expected bits. Go to SETTLE if DUT_LAT>0, else CHECK.
- SETTLE: count DUT_LAT cycles, then go to CHECK.
- CHECK (1 cycle): compare {dut_c,dut_cout,dut_s} against the expected bits.
  - On mismatch: err_cnt increments and saturates at 2^ERR_W-1. If first_err_vld=0, set first_err_vld=1 and first_err_idx=idx.
  - If idx==num_vec_latched-1: go to DONE. Otherwise idx++ and go to APPLY.
- Cycles per vector: DUT_LAT+2. Total run length: num_vec*(DUT_LAT+2) cycles from the start cycle until DONE entry.
- DONE: done=1 on the entry cycle only; busy=0; pass=(err_cnt==0); results held until the next start.
- Stimulus outputs hold their last value outside APPLY..CHECK.
- Boundary conditions:
  - num_vec>NUM_VEC is clamped to NUM_VEC.
  - start while busy is ignored.
  - wr_en while busy is dropped and has no RAM effect.
  - Simultaneous start and wr_en in IDLE: the write lands and the run starts; vector 0 reads the new data if wr_addr==0 (write-first).
- Reset mid-run: immediate return to IDLE with reset output values; RAM is retained.

Optional Feature:
- Macro: FTC_SEQ_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes directly to DONE. err_cnt=1 and first_err_idx=failing index; remaining vectors are skipped.
- Undefined: every vector runs regardless of mismatches.

Decomposition:
- Package ftc_seq_pkg holds:
  - state enum typedef;
  - vector-word field position localparams (CIN_B=7, I_HI=6, I_LO=3, C_B=2, COUT_B=1, S_B=0);
  - a vec_t packed struct for the 8-bit word.
- One natural sub-module: ftc_vec_ram, a NUM_VEC x 8 synchronous-write, asynchronous-read RAM with write-first bypass.

Test Plan:
- Load the 9-vector exhaustive-sample set of correct FTC results; num_vec=9, DUT_LAT=0, correct FTC model → done after exactly 18 cycles, pass=1, err_cnt=0, first_err_vld=0.
- Same set with vector 4's expected S bit inverted → err_cnt=1, first_err_vld=1, first_err_idx=4, pass=0.
- Model stuck-at-0 on S, all 9 vectors expecting some S=1 → err_cnt equals the count of S=1 vectors; first_err_idx = lowest such index. With FTC_SEQ_STOP_ON_ERR_EN: err_cnt=1 and an early done.
- DUT_LAT=2, num_vec=3 → done 12 cycles after start; dut_i stable through each SETTLE.
- num_vec=0 → done next cycle, pass=1. Start and wr_en pulsed mid-run → both ignored; RAM unchanged on readback.
- rst_n low during vector 5, then released → all outputs at reset values, busy=0. Rerun without reloading the RAM → pass=1.
